// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: drains LEN reads into a valid/ready stream, flags the last, pulses done.
// Optional stall counter port enabled by defining FIFO_READER_STALL_CNT_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_READ   = 1,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  clear,
  input  logic                                  start,
  input  logic [LEN_WIDTH-1:0]                  len,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  fifo_ren,
  input  logic signed [PAR_READ*DATA_WIDTH-1:0] fifo_dout,
  input  logic                                  fifo_empty,
  output logic signed [PAR_READ*DATA_WIDTH-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
`ifdef FIFO_READER_STALL_CNT_EN
  output logic [15:0]                           stall_cnt,
`endif
  output logic [1:0]                            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 pop;
  logic                 accept;
  logic                 last_pop;
  logic                 load;
  logic                 done_next;

  // Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_data/out_last are held stable while out_valid && !out_ready.
  assign accept   = out_valid && out_ready;
  assign pop      = (state == S_RUN) && !fifo_empty && (!out_valid || out_ready) && !clear;
  assign last_pop = pop && (remaining == LEN_WIDTH'(1));
  assign load     = (state == S_IDLE) && start && (len != '0) && !clear;
  assign fifo_ren = pop;
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) state_next = S_RUN;
            else           done_next  = 1'b1;
          end
        end
        S_RUN: begin
          if (last_pop) state_next = S_DRAIN;
        end
        S_DRAIN: begin
          if (accept && out_last) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_next;
      if (clear) begin
        // Anything already popped but not yet accepted is dropped here.
        remaining <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        if (load)     remaining <= len;
        else if (pop) remaining <= remaining - LEN_WIDTH'(1);

        if (pop) begin
          out_data  <= fifo_dout;
          out_valid <= 1'b1;
          out_last  <= (remaining == LEN_WIDTH'(1));
        end else if (accept) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

`ifdef FIFO_READER_STALL_CNT_EN
  // Cycles spent waiting on an empty FIFO during RUN; saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (clear || ((state == S_IDLE) && start)) begin
      stall_cnt <= '0;
    end else if ((state == S_RUN) && fifo_empty && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: scenario tasks against a queue-based FIFO/stream model.
module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int PR = 1;
  localparam int LW = 8;
  localparam int W  = PR * DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, fifo_ren, fifo_empty, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [W-1:0]  fifo_dout, out_data;
  logic [1:0]    state_dbg;
`ifdef FIFO_READER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  fifo_stream_reader #(.DATA_WIDTH(DW), .PAR_READ(PR), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .start(start), .len(len),
    .busy(busy), .done(done), .fifo_ren(fifo_ren), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
`ifdef FIFO_READER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Behavioural FIFO feeding the reader
  logic [W-1:0] mem [256];
  int wp = 0;
  int rp = 0;
  logic flush = 1'b0;
  assign fifo_empty = (wp == rp);
  assign fifo_dout  = mem[rp[7:0]];
  always @(posedge clk) begin
    if (flush)         rp <= wp;
    else if (fifo_ren) rp <= rp + 1;
  end
  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  // Stream recorder and protocol observers
  logic [W-1:0] got_q[$];
  logic         got_last_q[$];
  logic [W-1:0] exp_q[$];
  int done_cnt = 0, bad_ren = 0, bad_last = 0, ren_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (fifo_ren) ren_cnt++;
    if (fifo_ren && (fifo_empty || !busy || clear)) bad_ren++;
    if (out_last && !out_valid) bad_last++;
    if (rstn && !clear && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
    end
  end

  // Driver tasks (all called and returning at posedge+1)
  task automatic push_word(input logic [W-1:0] v);
    mem[wp[7:0]] = v;
    wp = wp + 1;
    exp_q.push_back(v);
  endtask

  task automatic clear_rec();
    got_q.delete(); got_last_q.delete(); exp_q.delete();
    done_cnt = 0; bad_ren = 0; bad_last = 0; ren_cnt = 0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic start_xfer(input int l);
    start = 1'b1;
    len = LW'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done_cnt > 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  // Compares the recorded stream against exp_q; last expected only on the final beat.
  task automatic check_stream(input string tag);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d beats expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_data[%0d]: got %0h expected %0h", tag, i, got_q[i], exp_q[i]);
      end
      n_checks++;
      if (got_last_q[i] !== (i == exp_q.size() - 1)) begin
        n_fail++; $display("FAIL %s_last[%0d]: got %0b expected %0b", tag, i, got_last_q[i], (i == exp_q.size() - 1));
      end
    end
    n_checks++;
    if (bad_ren != 0 || bad_last != 0) begin
      n_fail++; $display("FAIL %s_protocol: got bad_ren=%0d bad_last=%0d expected 0/0", tag, bad_ren, bad_last);
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b expected 0", out_last); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    n_checks++; if (fifo_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %0b expected 0", fifo_ren); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic h_ren[6], h_val[6], h_last[6], h_done[6];
    logic [W-1:0] h_data[6];
    clear_rec();
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) push_word(W'(v));
    start_xfer(4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      h_ren[c] = fifo_ren; h_val[c] = out_valid; h_last[c] = out_last;
      h_done[c] = done; h_data[c] = out_data;
    end
    @(posedge clk); #1;
    // Read k (1-based) pops in cycle k-1 and is presented in cycle k; done follows the last accept.
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (h_ren[c] !== (c < 4)) begin n_fail++; $display("FAIL basic_ren[%0d]: got %0b expected %0b", c, h_ren[c], (c < 4)); end
      n_checks++;
      if (h_val[c] !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL basic_valid[%0d]: got %0b expected %0b", c, h_val[c], (c >= 1 && c <= 4)); end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (h_data[c] !== exp_q[c-1]) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h expected %0h", c, h_data[c], exp_q[c-1]); end
      end
      n_checks++;
      if (h_last[c] !== (c == 4)) begin n_fail++; $display("FAIL basic_last[%0d]: got %0b expected %0b", c, h_last[c], (c == 4)); end
      n_checks++;
      if (h_done[c] !== (c == 5)) begin n_fail++; $display("FAIL basic_done[%0d]: got %0b expected %0b", c, h_done[c], (c == 5)); end
    end
    check_stream("basic");
  endtask

  task automatic test_backpressure();
    int stall = 2;
    int stalled = 0;
    clear_rec();
    out_ready = 1'b1;
    for (int v = 1; v <= 3; v++) push_word(W'(v));
    start_xfer(3);
    for (int k = 0; k < 30 && done_cnt == 0; k++) begin
      if (stall > 0 && out_valid && out_data == W'(2)) begin out_ready = 1'b0; stall--; end
      else out_ready = 1'b1;
      @(negedge clk);
      if (!out_ready) begin
        stalled++;
        n_checks++; if (out_data !== W'(2)) begin n_fail++; $display("FAIL bp_hold_data: got %0h expected 2", out_data); end
        n_checks++; if (fifo_ren !== 1'b0) begin n_fail++; $display("FAIL bp_ren: got %0b expected 0", fifo_ren); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b expected 1", out_valid); end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_checks++; if (stalled != 2) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 2", stalled); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    check_stream("bp");
  endtask

  task automatic test_empty_stall();
    int busy_drop = 0;
    bit ok;
    clear_rec();
    out_ready = 1'b1;
    start_xfer(2);
    repeat (5) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %0b expected 1", busy); end
      n_checks++; if (fifo_ren !== 1'b0) begin n_fail++; $display("FAIL stall_ren: got %0b expected 0", fifo_ren); end
      @(posedge clk); #1;
    end
    push_word(W'($urandom));
    push_word(W'($urandom));
    for (int k = 0; k < 20 && done_cnt == 0; k++) begin
      @(negedge clk);
      if (!done && busy !== 1'b1) busy_drop++;
      @(posedge clk); #1;
    end
    ok = (done_cnt == 1);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_done: got %0d expected 1", done_cnt); end
    n_checks++; if (busy_drop != 0) begin n_fail++; $display("FAIL stall_busy_drop: got %0d expected 0", busy_drop); end
`ifdef FIFO_READER_STALL_CNT_EN
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 5", stall_cnt); end
`endif
    check_stream("stall");
  endtask

  task automatic test_zero_len();
    clear_rec();
    out_ready = 1'b1;
    push_word(W'($urandom));
    exp_q.delete();
    start_xfer(0);
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0b expected 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %0b expected 0", busy); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %0b expected 0", done); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ren_cnt != 0) begin n_fail++; $display("FAIL zero_ren: got %0d expected 0", ren_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %0b expected 0", busy); end
    check_stream("zero");
    do_flush();
  endtask

  task automatic test_clear();
    logic [W-1:0] first;
    bit ok;
    clear_rec();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    first = exp_q[0];
    start_xfer(5);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ren_cnt != 2) begin n_fail++; $display("FAIL clr_pre_reads: got %0d expected 2", ren_cnt); end
    clear = 1'b1;
    @(negedge clk);
    n_checks++; if (fifo_ren !== 1'b0) begin n_fail++; $display("FAIL clr_ren: got %0b expected 0", fifo_ren); end
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %0b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %0b expected 0", busy); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL clr_no_done: got %0d expected 0", done_cnt); end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== first) begin n_fail++; $display("FAIL clr_accepted: got %0d beats expected 1 of %0h", got_q.size(), first); end
    do_flush();
    clear_rec();
    push_word(W'($urandom));
    start_xfer(1);
    wait_done(20, ok);
    n_checks++; if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL clr_restart_done: got %0d expected 1", done_cnt); end
    check_stream("clr_restart");
  endtask

  task automatic test_async_reset();
    clear_rec();
    out_ready = 1'b0;
    push_word(W'($urandom) | W'(1));
    start_xfer(1);
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got valid=%0b last=%0b expected 1/1", out_valid, out_last); end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL arst_last: got %0b expected 0", out_last); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL arst_data: got %0h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || fifo_ren !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: got busy=%0b done=%0b ren=%0b expected 0", busy, done, fifo_ren); end
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt != 0) begin n_fail++; $display("FAIL arst_idle: got busy=%0b valid=%0b dones=%0d expected 0", busy, out_valid, done_cnt); end
    do_flush();
  endtask

  task automatic test_back_to_back();
    int l;
    int written;
    bit ok;
    for (int t = 0; t < 6; t++) begin
      l = (t == 5) ? 255 : $urandom_range(1, 12);
      written = 0;
      clear_rec();
      out_ready = 1'b1;
      start_xfer(l);
      ok = 1'b0;
      for (int k = 0; k < l * 10 + 50; k++) begin
        if (done_cnt > 0) begin ok = 1'b1; break; end
        if (written < l && $urandom_range(0, 3) != 0) begin push_word(W'($urandom)); written++; end
        out_ready = ($urandom_range(0, 3) != 0);
        // A start while busy must be ignored.
        start = busy && ($urandom_range(0, 7) == 0);
        len = LW'($urandom_range(1, 20));
        @(posedge clk); #1;
      end
      start = 1'b0;
      out_ready = 1'b1;
      n_checks++; if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL b2b_done[%0d]: got %0d expected 1", t, done_cnt); end
      n_checks++; if (ren_cnt != l) begin n_fail++; $display("FAIL b2b_reads[%0d]: got %0d expected %0d", t, ren_cnt, l); end
      check_stream("b2b");
      do_flush();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_len();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
